// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter/sequencer for BRAM port A shared by the CPU (port 0) and DMA (port 1).
// Partial-word writes become read-modify-write. Out-of-range accesses complete with oob_err and never touch RAM.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_valid,
   input  logic [31:0]           p0_addr,
   input  logic [31:0]           p0_wdata,
   input  logic [3:0]            p0_wstrb,
   output logic                  p0_ready,
   output logic [31:0]           p0_rdata,
   input  logic                  p1_valid,
   input  logic [31:0]           p1_addr,
   input  logic [31:0]           p1_wdata,
   input  logic [3:0]            p1_wstrb,
   output logic                  p1_ready,
   output logic [31:0]           p1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  grant_id,
   output logic                  busy,
   output logic                  oob_err
);
   localparam int CW = $clog2(RD_LATENCY + 1) + 1;
   localparam logic [CW-1:0] LAT = CW'(RD_LATENCY);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_COMMIT, DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic                  r_last, w_last_nxt;
   logic                  r_gid, w_gid_nxt;
   logic [31:0]           r_wdata, w_wdata_nxt;
   logic [3:0]            r_wstrb, w_wstrb_nxt;
   logic                  r_oob, w_oob_nxt;
   logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
   logic                  r_mem_we, w_mem_we_nxt;
   logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
   logic                  r_rdy0, w_rdy0_nxt, r_rdy1, w_rdy1_nxt;
   logic [31:0]           r_rdata0, w_rdata0_nxt, r_rdata1, w_rdata1_nxt;
   logic                  r_oob_err, w_oob_err_nxt;
   logic                  r_busy;

   logic        w_req, w_sel, w_req_oob, w_is_rd, w_lat_hit, w_done;
   logic [31:0] w_req_addr, w_req_wdata, w_mask, w_merged;
   logic [3:0]  w_req_wstrb;
   logic        w_unused_addr_lsb;

   // On a tie the port that did not win last time is granted.
   assign w_req       = p0_valid | p1_valid;
   assign w_sel       = (p0_valid & p1_valid) ? ~r_last : p1_valid;
   assign w_req_addr  = w_sel ? p1_addr  : p0_addr;
   assign w_req_wdata = w_sel ? p1_wdata : p0_wdata;
   assign w_req_wstrb = w_sel ? p1_wstrb : p0_wstrb;
   assign w_req_oob   = |w_req_addr[31:ADDR_WIDTH+2];
   assign w_unused_addr_lsb = ^w_req_addr[1:0];

   assign w_is_rd   = (r_wstrb == 4'b0000);
   assign w_lat_hit = (r_cnt == LAT);
   assign w_mask    = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
   assign w_merged  = (mem_rdata & ~w_mask) | (r_wdata & w_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_last      <= 1'b1;
         r_gid       <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_oob       <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_rdy0      <= 1'b0;
         r_rdy1      <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
         r_oob_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_last      <= w_last_nxt;
         r_gid       <= w_gid_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wstrb     <= w_wstrb_nxt;
         r_oob       <= w_oob_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_rdy0      <= w_rdy0_nxt;
         r_rdy1      <= w_rdy1_nxt;
         r_rdata0    <= w_rdata0_nxt;
         r_rdata1    <= w_rdata1_nxt;
         r_oob_err   <= w_oob_err_nxt;
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (w_req_oob || w_req_wstrb == 4'b1111) w_state_nxt = WR_COMMIT;
               else                                     w_state_nxt = RD_WAIT;
            end
         end
         RD_WAIT:   if (w_lat_hit) w_state_nxt = w_is_rd ? DONE : WR_COMMIT;
         WR_COMMIT: w_state_nxt = DONE;
         DONE:      w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_last_nxt      = r_last;
      w_gid_nxt       = r_gid;
      w_wdata_nxt     = r_wdata;
      w_wstrb_nxt     = r_wstrb;
      w_oob_nxt       = r_oob;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_we_nxt    = 1'b0;
      w_mem_wdata_nxt = r_mem_wdata;
      w_rdata0_nxt    = r_rdata0;
      w_rdata1_nxt    = r_rdata1;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_gid_nxt      = w_sel;
               w_last_nxt     = w_sel;
               w_wdata_nxt    = w_req_wdata;
               w_wstrb_nxt    = w_req_wstrb;
               w_oob_nxt      = w_req_oob;
               w_mem_addr_nxt = w_req_addr[ADDR_WIDTH+1:2];
               w_cnt_nxt      = '0;
               if (!w_req_oob && w_req_wstrb == 4'b1111) begin
                  w_mem_wdata_nxt = w_req_wdata;
                  w_mem_we_nxt    = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_lat_hit) begin
               if (w_is_rd) begin
                  if (r_gid) w_rdata1_nxt = mem_rdata;
                  else       w_rdata0_nxt = mem_rdata;
               end else begin
                  w_mem_wdata_nxt = w_merged;
                  w_mem_we_nxt    = 1'b1;
               end
            end
         end
         WR_COMMIT: begin
            if (r_oob && w_is_rd) begin
               if (r_gid) w_rdata1_nxt = '0;
               else       w_rdata0_nxt = '0;
            end
         end
         default: ;
      endcase
      w_done        = (w_state_nxt == DONE);
      w_rdy0_nxt    = w_done & ~r_gid;
      w_rdy1_nxt    = w_done &  r_gid;
      w_oob_err_nxt = w_done &  r_oob;
   end

   assign p0_ready  = r_rdy0;
   assign p1_ready  = r_rdy1;
   assign p0_rdata  = r_rdata0;
   assign p1_rdata  = r_rdata1;
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign grant_id  = r_gid;
   assign busy      = r_busy;
   assign oob_err   = r_oob_err;
endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: a 2-stage registered BRAM model on port A, a transaction-level
// model predicting every cycle's handshake and RAM traffic, directed cases and random traffic.
module tb_mem_arbiter;
   localparam int AW  = 16;
   localparam int RDL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          p0_valid = 1'b0, p1_valid = 1'b0;
   logic [31:0]   p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
   logic [3:0]    p0_wstrb = '0, p1_wstrb = '0;
   logic          p0_ready, p1_ready;
   logic [31:0]   p0_rdata, p1_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata, mem_rdata;
   logic          grant_id, busy, oob_err;

   mem_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
      .p0_ready(p0_ready), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
      .p1_ready(p1_ready), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .grant_id(grant_id), .busy(busy), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'hAABBCCDD;
      return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0103);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // BRAM: address registered at one edge, data out two edges later
   logic [31:0] bram [0:(1<<AW)-1];
   logic [31:0] rd_pipe1, rd_pipe2;
   assign mem_rdata = rd_pipe2;
   initial begin
      for (int i = 0; i < (1<<AW); i++) bram[i] = init_word(i);
      rd_pipe1 = '0;
      rd_pipe2 = '0;
      forever begin
         @(posedge clk);
         rd_pipe2 <= rd_pipe1;
         rd_pipe1 <= bram[mem_addr];
         if (mem_we) bram[mem_addr] <= mem_wdata;
      end
   end

   // Transaction model state and monitors
   logic [31:0] ref_mem [0:(1<<AW)-1];
   bit          m_armed = 0, m_has = 0, m_last = 1, m_gid = 0, m_oob = 0, m_rd = 0;
   int          m_g = 0, m_done = -1, m_free = 0, m_we_cyc = -1;
   logic [AW-1:0] m_wa = '0;
   logic [31:0] m_we_dat = '0, m_exp_rdata = '0;
   int          we_cnt = 0, last_we_cyc = -1, rdy0_cnt = 0;
   logic [31:0] last_we_addr = '0, last_we_dat = '0;
   logic [31:0] addr_hist [0:255];
   int          done_order[$];

   initial begin
      int c, lat;
      bit act, fin, sel;
      logic [31:0] a, d;
      logic [3:0] s;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         c = cyc;
         if (mem_we === 1'b1) begin
            we_cnt++;
            last_we_cyc  = c;
            last_we_addr = 32'(mem_addr);
            last_we_dat  = mem_wdata;
         end
         if (p0_ready === 1'b1) rdy0_cnt++;
         addr_hist[c % 256] = 32'(mem_addr);
         if (m_armed) begin
            act = m_has && c > m_g && c <= m_done;
            fin = act && c == m_done;
            chk("busy", 32'(busy), 32'(act));
            chk("p0_ready", 32'(p0_ready), 32'(fin && !m_gid));
            chk("p1_ready", 32'(p1_ready), 32'(fin && m_gid));
            chk("oob_err", 32'(oob_err), 32'(fin && m_oob));
            chk("mem_we", 32'(mem_we), 32'(act && c == m_we_cyc));
            if (act) chk("grant_id", 32'(grant_id), 32'(m_gid));
            if (act && c == m_g + 1 && !m_oob) chk("mem_addr_at_grant", 32'(mem_addr), 32'(m_wa));
            if (act && c == m_we_cyc) begin
               chk("we_addr", 32'(mem_addr), 32'(m_wa));
               chk("we_data", mem_wdata, m_we_dat);
               ref_mem[m_wa] = m_we_dat;
            end
            if (fin && m_rd) chk("rdata", m_gid ? p1_rdata : p0_rdata, m_exp_rdata);
         end
         if (rst) begin
            m_armed = 1;
            m_has   = 0;
            m_last  = 1;
            m_free  = c + 1;
         end else if (m_armed && c >= m_free && (p0_valid || p1_valid)) begin
            sel = (p0_valid && p1_valid) ? !m_last : p1_valid;
            a = sel ? p1_addr  : p0_addr;
            d = sel ? p1_wdata : p0_wdata;
            s = sel ? p1_wstrb : p0_wstrb;
            m_gid = sel; m_last = sel; m_g = c; m_has = 1;
            m_wa = a[AW+1:2];
            m_oob = (a >> (AW + 2)) != 0;
            m_rd = (s == 4'h0);
            m_we_cyc = -1;
            m_exp_rdata = '0;
            if (m_oob) lat = 2;
            else if (s == 4'hF) begin
               lat = 2; m_we_cyc = c + 1; m_we_dat = d;
            end else if (s == 4'h0) begin
               lat = RDL + 2; m_exp_rdata = ref_mem[m_wa];
            end else begin
               lat = RDL + 3; m_we_cyc = c + RDL + 2; m_we_dat = merge(ref_mem[m_wa], d, s);
            end
            m_done = c + lat;
            m_free = m_done + 1;
         end
      end
   end

   task automatic txn(input int port, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int c0, output int rc, output logic [31:0] rdat, output logic oerr,
                      output logic other_rdy);
      @(posedge clk); #1;
      if (port == 0) begin p0_valid = 1; p0_addr = a; p0_wdata = d; p0_wstrb = s; end
      else           begin p1_valid = 1; p1_addr = a; p1_wdata = d; p1_wstrb = s; end
      c0 = cyc; rc = -1; rdat = '0; oerr = 0; other_rdy = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if ((port == 0) ? p0_ready : p1_ready) begin
            rc = cyc;
            rdat = (port == 0) ? p0_rdata : p1_rdata;
            oerr = oob_err;
            other_rdy = (port == 0) ? p1_ready : p0_ready;
            break;
         end
      end
      if (port == 0) p0_valid = 0; else p1_valid = 0;
      if (rc < 0) begin
         n_tests++; n_fail++;
         $display("FAIL ready_timeout: port %0d got no ready, required within 80 cycles", port);
      end else done_order.push_back(port);
   endtask

   task automatic requester(input int port, input int n);
      int r, c0, rc;
      logic [31:0] a, rdat;
      logic [3:0] s;
      logic oerr, orr;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         r = $urandom_range(0, 99);
         if (r < 15)      a = $urandom() | (32'h1 << $urandom_range(AW + 2, 31));
         else if (r < 25) a = (32'((1 << AW) - 1) << 2) | 32'($urandom_range(0, 3));
         else             a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         r = $urandom_range(0, 99);
         if (r < 40)      s = 4'h0;
         else if (r < 65) s = 4'hF;
         else             s = 4'($urandom_range(1, 14));
         txn(port, a, $urandom(), s, c0, rc, rdat, oerr, orr);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, rc, we0, r0;
      logic [31:0] rdat, saved;
      logic oerr, orr;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_grant_id", 32'(grant_id), 0);

      // Read of word 0x10
      txn(0, 32'h40, 32'h0, 4'h0, c0, rc, rdat, oerr, orr);
      chk("rd_latency", 32'(rc - c0), 4);
      chk("rd_data", rdat, 32'hAABBCCDD);
      chk("rd_p1_ready", 32'(orr), 0);
      chk("rd_mem_addr", addr_hist[(c0 + 1) % 256], 32'h10);

      // Partial write 0101 becomes read-modify-write
      we0 = we_cnt;
      txn(0, 32'h40, 32'h11223344, 4'b0101, c0, rc, rdat, oerr, orr);
      chk("pw_latency", 32'(rc - c0), 5);
      chk("pw_we_count", 32'(we_cnt - we0), 1);
      chk("pw_we_data", last_we_dat, 32'hAA22CC44);
      chk("pw_we_cycle", 32'(last_we_cyc - c0), 4);
      txn(0, 32'h40, 32'h0, 4'h0, c0, rc, rdat, oerr, orr);
      chk("pw_readback", rdat, 32'hAA22CC44);

      // Full write from port 1
      txn(1, 32'h80, 32'hDEADBEEF, 4'hF, c0, rc, rdat, oerr, orr);
      chk("fw_latency", 32'(rc - c0), 2);
      chk("fw_we_cycle", 32'(last_we_cyc - c0), 1);
      chk("fw_we_addr", last_we_addr, 32'h20);

      // Out-of-range read and write
      we0 = we_cnt;
      txn(0, 32'h0004_0000, 32'h12345678, 4'h0, c0, rc, rdat, oerr, orr);
      chk("oob_rd_latency", 32'(rc - c0), 2);
      chk("oob_rd_data", rdat, 32'h0);
      chk("oob_rd_err", 32'(oerr), 1);
      txn(1, 32'h8000_0040, 32'h12345678, 4'hF, c0, rc, rdat, oerr, orr);
      chk("oob_wr_err", 32'(oerr), 1);
      chk("oob_no_we", 32'(we_cnt - we0), 0);

      // Highest in-range word
      txn(1, 32'h0003_FFFE, 32'hCAFEF00D, 4'hF, c0, rc, rdat, oerr, orr);
      chk("top_we_addr", last_we_addr, 32'hFFFF);
      chk("top_err", 32'(oerr), 0);
      txn(0, 32'h0003_FFFC, 32'h0, 4'h0, c0, rc, rdat, oerr, orr);
      chk("top_readback", rdat, 32'hCAFEF00D);

      // Both ports reading continuously from reset alternate
      do_reset();
      done_order.delete();
      fork
         begin
            int a0, b0; logic [31:0] d0; logic e0, f0;
            txn(0, 32'h40, 32'h0, 4'h0, a0, b0, d0, e0, f0);
            txn(0, 32'h44, 32'h0, 4'h0, a0, b0, d0, e0, f0);
         end
         begin
            int a1, b1; logic [31:0] d1; logic e1, f1;
            txn(1, 32'h80, 32'h0, 4'h0, a1, b1, d1, e1, f1);
            txn(1, 32'h84, 32'h0, 4'h0, a1, b1, d1, e1, f1);
         end
      join
      chk("rr_count", 32'(done_order.size()), 4);
      if (done_order.size() == 4) begin
         chk("rr_order0", 32'(done_order[0]), 0);
         chk("rr_order1", 32'(done_order[1]), 1);
         chk("rr_order2", 32'(done_order[2]), 0);
         chk("rr_order3", 32'(done_order[3]), 1);
      end

      // Reset during the read phase of a partial write
      saved = bram[17];
      r0 = rdy0_cnt;
      @(posedge clk); #1;
      p0_valid = 1; p0_addr = 32'h44; p0_wdata = 32'hFFFF_FFFF; p0_wstrb = 4'b0011;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0; p0_valid = 0;
      @(negedge clk);
      chk("rstmid_mem_we", 32'(mem_we), 0);
      chk("rstmid_busy", 32'(busy), 0);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("rstmid_ram_kept", bram[17], saved);
      chk("rstmid_no_ready", 32'(rdy0_cnt - r0), 0);

      // Random traffic from both ports
      fork
         requester(0, 40);
         requester(1, 40);
      join
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single CPU-side port (port A) of the main 32-bit block RAM.
- Each requester uses a picorv32-style native bus: valid/ready, byte address, wstrb.
- Port 0 is the picorv32 core; port 1 is a DMA/blitter engine.
- The block grants round-robin, issues the BRAM address, waits for the registered read latency, and builds partial-word writes as read-modify-write. Full-word writes go straight to RAM.

Parameters:
ADDR_WIDTH, 16, BRAM word-address width (depth = 2^ADDR_WIDTH words)
RD_LATENCY, 2, edges from mem_addr update until mem_rdata valid (2 = HIGH_PERFORMANCE BRAM)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
p0_valid  input  1  port 0 request
p0_addr  input  32  port 0 byte address
p0_wdata  input  32  port 0 write data
p0_wstrb  input  4  port 0 byte strobes; 0000 = read
p0_ready  output  1  port 0 one-cycle completion pulse
p0_rdata  output  32  port 0 read data, valid while p0_ready
p1_valid, p1_addr, p1_wdata, p1_wstrb, p1_ready, p1_rdata  (same as port 0, for port 1)
mem_addr  output  ADDR_WIDTH  BRAM word address
mem_we  output  1  BRAM write enable
mem_wdata  output  32  BRAM write data
mem_rdata  input  32  BRAM read data
grant_id  output  1  port currently owning the RAM (valid while busy)
busy  output  1  high in any state other than IDLE
oob_err  output  1  one-cycle pulse, coincident with ready, on an out-of-range access

Behaviour:
- Reset values: all outputs registered; mem_addr=0, mem_we=0, mem_wdata=0, p*_ready=0, p*_rdata=0, grant_id=0, busy=0, oob_err=0. State=IDLE, last_grant=1 (so port 0 wins the first tie).
- Reset mid-transaction aborts at the next edge: state IDLE, mem_we=0, no ready pulse. A write that was already committed stays in RAM.
- States: IDLE, RD_WAIT, WR_COMMIT, DONE.
- Requests are sampled only at an edge ending an IDLE cycle. The DONE cycle is never a sampling point, so a requester still holding valid during its ready cycle is not re-granted.
- Requester rule: once valid is high, addr, wdata and wstrb must stay stable until ready. The arbiter latches them at grant.
- Arbitration:
  - One valid port: grant it.
  - Both valid: grant the port != last_grant.
  - last_grant and grant_id update at grant.
- Word address: wa = addr[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
- Out of range (any addr[31:ADDR_WIDTH+2] bit set):
  - Read returns rdata=0; write is dropped (mem_we stays 0).
  - Sequencing length is the same as for a full-word write: DONE after one cycle.
  - oob_err pulses together with ready.
- Read (wstrb=0000):
  - At the grant edge G: mem_addr<=wa, state RD_WAIT, counter=0.
  - The counter increments each edge. At edge G+RD_LATENCY+1, p_rdata<=mem_rdata, then DONE.
- Full write (wstrb=1111):
  - At G: mem_addr<=wa, mem_wdata<=wdata, mem_we<=1, state WR_COMMIT.
  - Next edge: mem_we<=0, DONE.
- Partial write (any other nonzero wstrb):
  - Read phase is identical to a read.
  - At edge G+RD_LATENCY+1: mem_wdata <= (mem_rdata & ~M) | (wdata & M), where M expands each wstrb bit to 8 bits. Also mem_we<=1, state WR_COMMIT.
  - Next edge: mem_we<=0, DONE.
- DONE: the granted port's ready=1 for exactly one cycle, then IDLE. The other port's ready stays 0.
- mem_we is never high for more than one consecutive cycle.
- Latency from valid first high in cycle 0 (arbiter IDLE) to ready high:
  - Read: cycle RD_LATENCY+2.
  - Full write: cycle 2.
  - Partial write: cycle RD_LATENCY+3.
- Back-to-back: the minimum gap between successive grants is one IDLE cycle after DONE.

Test Plan:
- RAM word 0x10 = 0xAABBCCDD; p0 read addr 0x40, valid in cycle 0 -> mem_addr=0x10 in cycle 1; p0_ready only in cycle 4 with p0_rdata=0xAABBCCDD; p1_ready=0.
- p0 write addr 0x40, wdata 0x11223344, wstrb 0101, old word 0xAABBCCDD -> mem_we high one cycle with mem_wdata=0xAA22CC44; p0_ready in cycle 5; a subsequent read returns 0xAA22CC44.
- p1 full write wstrb 1111 addr 0x80, wdata 0xDEADBEEF -> mem_we in cycle 1 with mem_addr=0x20; p1_ready in cycle 2.
- p0 and p1 both valid continuously from reset, both reading -> grant order p0, p1, p0, p1, with grant_id alternating and no port granted twice in a row.
- p0 read addr 0x0004_0000 (above 2^18 bytes) -> mem_we never asserted; p0_rdata=0; p0_ready and oob_err both in cycle 2.
- rst asserted in cycle 3 of a partial write -> mem_we=0 and busy=0 from cycle 4; no p0_ready; RAM word unchanged.
